// File: rtl/aes_stream_if.sv
// Word-stream port bundle for aes_stream_ctrl: key load, plaintext in, ciphertext out.
// A word moves on a cycle where valid && ready are both high at the rising clock edge.
// The sender holds data stable while valid && !ready and does not drop valid before the handshake.
interface aes_stream_if;
  logic [127:0] key_in;
  logic         key_load;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  key_in, key_load, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output key_in, key_load, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/aes_stream_ctrl.sv
// Front/back end for a 128-bit AES core: packs four input words into a block, starts the
// core, waits for done (with stale-done masking and a timeout), then streams four output words.
module aes_stream_ctrl #(
  parameter int unsigned MIN_LAT = 2,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  aes_stream_if.slave   s,
  output logic [127:0]  aes_plaintext,
  output logic [127:0]  aes_key,
  output logic          aes_start,
  input  logic          aes_done,
  input  logic [127:0]  aes_ciphertext,
  output logic          busy,
  output logic          timeout_err,
  output logic [1:0]    dbg_state
);

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     word_cnt_q, word_cnt_d;
  logic [1:0]     out_cnt_q, out_cnt_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   ct_q, ct_d;
  logic           timeout_err_q, timeout_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      word_cnt_q    <= '0;
      out_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      pt_q          <= '0;
      key_q         <= '0;
      ct_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      out_cnt_q     <= out_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      pt_q          <= pt_d;
      key_q         <= key_d;
      ct_q          <= ct_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    out_cnt_d     = out_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    pt_d          = pt_q;
    key_d         = key_q;
    ct_d          = ct_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      COLLECT: begin
        // Key loads only land here, so the core sees one key for the whole block.
        if (s.key_load) key_d = s.key_in;
        if (s.in_valid) begin
          case (word_cnt_q)
            2'd0:    pt_d[127:96] = s.in_data;
            2'd1:    pt_d[95:64]  = s.in_data;
            2'd2:    pt_d[63:32]  = s.in_data;
            default: pt_d[31:0]   = s.in_data;
          endcase
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'd3) state_d = START;
        end
      end
      START: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
        // done may still be high from the previous block for the first MIN_LAT cycles.
        if (wait_cnt_q >= WCW'(MIN_LAT) && aes_done) begin
          ct_d      = aes_ciphertext;
          out_cnt_d = '0;
          state_d   = DRAIN;
        end else if (wait_cnt_q >= WCW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = COLLECT;
        end
      end
      DRAIN: begin
        if (s.out_ready) begin
          out_cnt_d = out_cnt_q + 2'd1;
          if (out_cnt_q == 2'd3) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    case (out_cnt_q)
      2'd0:    s.out_data = ct_q[127:96];
      2'd1:    s.out_data = ct_q[95:64];
      2'd2:    s.out_data = ct_q[63:32];
      default: s.out_data = ct_q[31:0];
    endcase
  end

  assign s.in_ready     = (state_q == COLLECT);
  assign s.out_valid    = (state_q == DRAIN);
  assign aes_start      = (state_q == START);
  assign aes_plaintext  = pt_q;
  assign aes_key        = key_q;
  assign busy           = (state_q != COLLECT) || (word_cnt_q != 2'd0);
  assign timeout_err    = timeout_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: AES core stub, stream drivers, scoreboard of expected output words.
module tb_aes_stream_ctrl;
  localparam int MIN_LAT = 2;
  localparam int TIMEOUT = 32;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  aes_stream_if sif();
  logic [127:0] aes_plaintext, aes_key, aes_ciphertext;
  logic aes_start, aes_done, busy, timeout_err;
  logic [1:0] dbg_state;

  aes_stream_ctrl #(.MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .s(sif),
    .aes_plaintext(aes_plaintext), .aes_key(aes_key), .aes_start(aes_start),
    .aes_done(aes_done), .aes_ciphertext(aes_ciphertext),
    .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / globals ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [31:0] exp_q[$];
  logic [127:0] model_key = '0;
  int core_mode = 0;   // 0 normal latency, 1 done stuck high, 2 never done
  int core_lat = 3;
  int start_cnt = 0, start_cyc = -1, acc_cyc = 0;
  int out_hs = 0, ov_cycles = 0, ov_rise_cyc = -1;
  bit rdy_rand = 0;

  // Stand-in for the AES core: the FIPS-197 C.1 vector, otherwise a keyed scramble.
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] k);
    if (pt == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return pt ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  // ---------------- core stub ----------------
  always begin : core_stub
    int k;
    @(posedge clk); #1;
    if (!rst_n) begin
      aes_done = 1'b0; aes_ciphertext = '0; start_cyc = -1;
    end else begin
      if (aes_start) begin start_cnt++; start_cyc = cyc; end
      k = (start_cyc < 0) ? -1 : cyc - start_cyc;
      case (core_mode)
        0: begin
          if (k == 0) aes_done = 1'b0;
          else if (k == core_lat) begin
            aes_done = 1'b1; aes_ciphertext = core_fn(aes_plaintext, aes_key);
          end
        end
        1: begin
          aes_done = 1'b1;
          if (k == 0) aes_ciphertext = 128'hdeaddeaddeaddeaddeaddeaddeaddead;
          else if (k == 2) aes_ciphertext = 128'hbadbadbadbadbadbadbadbadbadbad00;
          else if (k == 3) aes_ciphertext = core_fn(aes_plaintext, aes_key);
        end
        default: aes_done = 1'b0;
      endcase
    end
  end

  always begin : rdy_driver
    @(posedge clk); #1;
    if (rdy_rand) sif.out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    logic prev_stall, prev_start, prev_ov;
    logic [31:0] prev_data;
    if (!rst_n) begin
      prev_stall = 0; prev_start = 0; prev_ov = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (sif.out_valid !== 1'b1 || sif.out_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", sif.out_valid, sif.out_data, prev_data);
        end
      end
      if (sif.out_valid && sif.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %h with no word expected", sif.out_data);
        end else begin
          e = exp_q.pop_front();
          if (sif.out_data !== e) begin
            errors++;
            $display("FAIL out_word: got %h expected %h", sif.out_data, e);
          end
        end
        out_hs++;
      end
      if (aes_start) begin
        checks++;
        if (prev_start) begin errors++; $display("FAIL start_pulse: aes_start high 2 cycles, required 1"); end
      end
      if (sif.out_valid) ov_cycles++;
      if (sif.out_valid && !prev_ov) ov_rise_cyc = cyc;
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_data  = sif.out_data;
      prev_start = aes_start;
      prev_ov    = sif.out_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] w);
    int g = 0;
    sif.in_data = w; sif.in_valid = 1'b1;
    while (sif.in_ready !== 1'b1 && g < 300) begin tick(); g++; end
    if (g >= 300) begin
      checks++; errors++;
      $display("FAIL in_accept_timeout: in_ready=%b after %0d cycles, required 1", sif.in_ready, g);
    end
    acc_cyc = cyc;
    tick();
    sif.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input bit expect_out, input int lat);
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) begin
      send_word(blk[127-32*i -: 32]);
      if (i == 0) core_lat = lat;
    end
    if (expect_out) begin
      ct = core_fn(blk, model_key);
      for (int i = 0; i < 4; i++) exp_q.push_back(ct[127-32*i -: 32]);
    end
  endtask

  task automatic load_key(input logic [127:0] k, input bit take);
    sif.key_in = k; sif.key_load = 1'b1;
    tick();
    sif.key_load = 1'b0;
    if (take) model_key = k;
  endtask

  task automatic wait_drain(input int target, input bit chk_in_ready);
    int g = 0;
    while (out_hs < target && g < 400) begin
      if (chk_in_ready) begin
        checks++;
        if (sif.in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_low: got %b required 0", sif.in_ready); end
      end
      tick(); g++;
    end
    if (g >= 400) begin
      checks++; errors++;
      $display("FAIL drain_timeout: handshakes=%0d required %0d", out_hs, target);
    end
  endtask

  task automatic wait_ov();
    int g = 0;
    while (sif.out_valid !== 1'b1 && g < 100) begin tick(); g++; end
    if (g >= 100) begin checks++; errors++; $display("FAIL out_valid_timeout: out_valid=%b required 1", sif.out_valid); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; sif.in_valid = 0; sif.in_data = '0; sif.key_load = 0; sif.key_in = '0; sif.out_ready = 1;
    model_key = '0;
    tick(2);
    checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", sif.in_ready); end
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", sif.out_valid); end
    checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL reset_aes_start: got %b required 0", aes_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b required 0", timeout_err); end
    checks++; if (aes_key !== '0) begin errors++; $display("FAIL reset_aes_key: got %h required 0", aes_key); end
    checks++; if (aes_plaintext !== '0) begin errors++; $display("FAIL reset_plaintext: got %h required 0", aes_plaintext); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fips();
    int base = out_hs, s0 = start_cnt, t;
    load_key(FIPS_KEY, 1);
    checks++; if (aes_key !== FIPS_KEY) begin errors++; $display("FAIL fips_key: got %h required %h", aes_key, FIPS_KEY); end
    send_block(FIPS_PT, 1, 5);
    t = acc_cyc;
    wait_drain(base + 4, 1);
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL fips_start_count: got %0d required 1", start_cnt - s0); end
    checks++; if (start_cyc != t + 1) begin errors++; $display("FAIL fips_start_cycle: got %0d required %0d", start_cyc, t + 1); end
    checks++; if (ov_rise_cyc < t + 2 + MIN_LAT) begin errors++; $display("FAIL fips_latency: out_valid at %0d, required >= %0d", ov_rise_cyc, t + 2 + MIN_LAT); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fips_words_left: got %0d required 0", exp_q.size()); end
    checks++; if (sif.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fips_idle: in_ready=%b busy=%b required 1/0", sif.in_ready, busy); end
  endtask

  task automatic test_stale_done();
    int base = out_hs, s;
    core_mode = 1;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1, 3);
    s = acc_cyc + 1;
    while (cyc < s + 3) tick();
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL stale_early: out_valid=%b at wait_cnt 2, required 0", sif.out_valid); end
    tick();
    checks++; if (sif.out_valid !== 1'b1) begin errors++; $display("FAIL stale_capture: out_valid=%b after wait_cnt 2, required 1", sif.out_valid); end
    wait_drain(base + 4, 0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stale_words_left: got %0d required 0", exp_q.size()); end
    core_mode = 0;
  endtask

  task automatic test_backpressure();
    int base = out_hs, g = 0;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1, 4);
    wait_ov();
    sif.out_ready = 1'b0;
    tick(5);
    while (out_hs < base + 4 && g < 100) begin
      sif.out_ready = ~sif.out_ready; tick(); g++;
    end
    sif.out_ready = 1'b1;
    tick();
    checks++; if (out_hs != base + 4) begin errors++; $display("FAIL bp_count: got %0d words required 4", out_hs - base); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_words_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_key_protect();
    int base = out_hs;
    logic [127:0] old_k = model_key;
    logic [127:0] new_k = {$urandom, $urandom, $urandom, $urandom};
    sif.out_ready = 1'b0;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1, 8);
    tick(2);
    load_key(new_k, 0);
    checks++; if (aes_key !== old_k) begin errors++; $display("FAIL key_wait: got %h required %h", aes_key, old_k); end
    wait_ov();
    load_key(new_k, 0);
    checks++; if (aes_key !== old_k) begin errors++; $display("FAIL key_drain: got %h required %h", aes_key, old_k); end
    sif.out_ready = 1'b1;
    wait_drain(base + 4, 0);
    load_key(new_k, 1);
    checks++; if (aes_key !== new_k) begin errors++; $display("FAIL key_collect: got %h required %h", aes_key, new_k); end
    send_block({$urandom, $urandom, $urandom, $urandom}, 1, 3);
    wait_drain(base + 8, 0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL key_words_left: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int base, s, ov0 = ov_cycles;
    core_mode = 2;
    send_block({$urandom, $urandom, $urandom, $urandom}, 0, 3);
    s = acc_cyc + 1;
    while (cyc < s + TIMEOUT - 1) tick();
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early: timeout_err=%b busy=%b required 0/1", timeout_err, busy); end
    while (cyc < s + TIMEOUT + 1) tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %b required 1", timeout_err); end
    checks++; if (sif.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_idle: in_ready=%b busy=%b required 1/0", sif.in_ready, busy); end
    checks++; if (ov_cycles != ov0) begin errors++; $display("FAIL to_no_out: out_valid cycles=%0d required 0", ov_cycles - ov0); end
    core_mode = 0;
    base = out_hs;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1, 6);
    wait_drain(base + 4, 0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL to_next_block: words left %0d required 0", exp_q.size()); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b required 1", timeout_err); end
  endtask

  task automatic abort_reset(input string tag);
    rst_n = 1'b0;
    #1;
    exp_q.delete(); model_key = '0;
    checks++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0 || sif.in_ready !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: out_valid=%b busy=%b in_ready=%b timeout_err=%b required 0/0/1/0", tag, sif.out_valid, busy, sif.in_ready, timeout_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int base, g = 0;
    send_word($urandom); send_word($urandom);
    abort_reset("rst_collect");
    load_key({$urandom, $urandom, $urandom, $urandom}, 1);
    base = out_hs;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1, 4);
    wait_drain(base + 4, 0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_collect_next: words left %0d required 0", exp_q.size()); end
    base = out_hs;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1, 4);
    while (out_hs < base + 2 && g < 100) begin tick(); g++; end
    abort_reset("rst_drain");
    base = out_hs;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1, 2);
    wait_drain(base + 4, 0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_drain_next: words left %0d required 0", exp_q.size()); end
  endtask

  task automatic test_random_b2b();
    int tgt = out_hs;
    rdy_rand = 1;
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 2) == 0) begin
        wait_drain(tgt, 0);
        load_key({$urandom, $urandom, $urandom, $urandom}, 1);
      end
      send_block({$urandom, $urandom, $urandom, $urandom}, 1, $urandom_range(1, 12));
      tgt += 4;
    end
    wait_drain(tgt, 0);
    rdy_rand = 0;
    sif.out_ready = 1'b1;
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_words_left: got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_stale_done();
    test_backpressure();
    test_key_protect();
    test_timeout();
    test_reset_mid();
    test_random_b2b();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
- Word-stream front/back end for the 128-bit AES encryption core.
- Collects four 32-bit plaintext words into one block and drives the core's plaintext, key and start inputs.
- Waits for the core's done, captures the 128-bit ciphertext, and returns it as four 32-bit words over a valid/ready output.
- Sits directly upstream and downstream of the core. One block in flight at a time.

Parameters:
- MIN_LAT, 2: cycles after aes_start during which aes_done is ignored; the core's done flag can be stale-high from the previous block.
- TIMEOUT, 32: maximum WAIT cycles counted from the aes_start cycle before the block is abandoned (TIMEOUT > MIN_LAT).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- key_in  in  128  AES key
- key_load  in  1  capture key_in into key register
- in_data  in  32  plaintext word
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts a word
- out_data  out  32  ciphertext word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts a word
- aes_plaintext  out  128  block to core
- aes_key  out  128  key to core
- aes_start  out  1  one-cycle start pulse to core
- aes_done  in  1  core done (level)
- aes_ciphertext  in  128  core result
- busy  out  1  block in progress
- timeout_err  out  1  sticky: a block timed out

Behaviour:
- Clock and reset: clk is the clock. rst_n is asynchronous, active-low.
- Reset values:
  - State COLLECT.
  - Word, out and wait counters 0.
  - Plaintext, key and ciphertext registers 0.
  - timeout_err 0.
- Decoded outputs: in_ready = (state==COLLECT). out_valid = (state==DRAIN). aes_start = (state==START). After reset: in_ready=1, out_valid=0, aes_start=0.
- busy = (state!=COLLECT) or (word_cnt!=0).
- Byte order is FIPS-197 big-endian:
  - Input word 0 lands in plaintext[127:96], word 3 in [31:0].
  - Output word 0 is ciphertext[127:96].
- COLLECT:
  - On in_valid&&in_ready, store in_data at slot word_cnt and increment word_cnt (2-bit).
  - On acceptance of word 3, word_cnt wraps to 0 and the next state is START.
  - key_load is honoured only in COLLECT; it is ignored in all other states, so aes_key never changes mid-block.
  - If key_load and a word handshake occur in the same cycle, both take effect.
- START:
  - aes_start=1 for exactly one cycle.
  - wait_cnt cleared to 0.
  - Next state WAIT.
- WAIT:
  - wait_cnt increments every cycle.
  - aes_done is ignored while wait_cnt < MIN_LAT.
  - When wait_cnt >= MIN_LAT and aes_done=1: capture aes_ciphertext, clear out_cnt, next state DRAIN.
  - If aes_done is not seen and the cycle count since the aes_start cycle reaches TIMEOUT: set timeout_err, discard the block, return to COLLECT. A valid done in that same cycle takes priority over the timeout.
- Stability: aes_plaintext and aes_key are constant from START through the last WAIT cycle.
- DRAIN:
  - out_data = ciphertext word out_cnt.
  - out_data is held stable while out_valid && !out_ready.
  - On each handshake, out_cnt increments.
  - After the handshake on word 3, next state COLLECT; out_valid drops the following cycle.
- Latency: 4th input word accepted at cycle T → aes_start at T+1 → first out_valid no earlier than T+2+MIN_LAT.
- Back-pressure: in_ready is 0 in START, WAIT and DRAIN, so no input is accepted until the output block fully drains.
- Reset mid-operation (any state): immediate return to reset values. A partial block, the captured key and the ciphertext are lost. The core's start is not reissued.
- timeout_err is cleared only by reset.

Test Plan:
- FIPS-197 C.1 (core model attached):
  - key_load with key 000102030405060708090a0b0c0d0e0f.
  - Feed 00112233, 44556677, 8899aabb, ccddeeff.
  - Expect out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
  - Expect exactly one aes_start pulse and in_ready=0 from T+1 until the last out handshake.
- Output back-pressure:
  - Hold out_ready=0 for 5 cycles, then toggle it 1/0 every cycle.
  - out_data must be stable while stalled; exactly 4 words in order; no duplicates or drops.
- Stale done:
  - Stub drives aes_done=1 constantly.
  - Capture must occur at wait_cnt==MIN_LAT (2), not earlier.
  - aes_ciphertext changed at wait_cnt 1 must not be captured.
- Timeout:
  - Stub never asserts aes_done.
  - timeout_err rises TIMEOUT=32 cycles after the aes_start cycle; state returns to COLLECT; out_valid never asserted.
  - A following block still completes normally.
- Key protection: pulse key_load with a new key during WAIT and during DRAIN. aes_key stays at the old key; the new key is accepted only in COLLECT.
- Reset mid-block: deassert rst_n after 2 input words, and separately after out word 1 in DRAIN.
  - Expect out_valid=0, busy=0, in_ready=1 immediately.
  - The next full block produces the correct ciphertext with no residue from the aborted block.
